// File: rtl/int_ctrl_v1.sv
// Interrupt controller: sticky event flags, per-source enables, fixed-priority
// arbitration and a req/ack/done handshake toward the CPU.
module int_ctrl_v1 #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = 32'hFFFFF864,
    parameter int unsigned            N_SRC      = 14
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [ADDR_WIDTH-1:0]   sys_addr,
    input  logic                    sys_wr_en,
    input  logic [DATA_WIDTH-1:0]   sys_sw_value,
    input  logic [N_SRC-1:0]        src_event,
    input  logic                    irq_ack,
    input  logic                    irq_done,
    output logic [DATA_WIDTH-1:0]   sfr_rd_dout,
    output logic                    irq_req,
    output logic [4:0]              irq_id
);

    localparam int unsigned ID_W = 5;

    localparam logic [ADDR_WIDTH-1:0] ADDR_EN   = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] ADDR_FLG  = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_VEC  = BASE_ADDR + ADDR_WIDTH'(12);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [N_SRC-1:0]   inten;
    logic [N_SRC-1:0]   flg;
    logic [N_SRC-1:0]   flg_nxt;
    logic               gie;

    logic [N_SRC-1:0]   pending;
    logic [31:0]        pend_ext;
    logic [ID_W-1:0]    winner;
    logic               req_nxt;
    logic [ID_W-1:0]    id_nxt;

    logic               sel_en;
    logic               sel_flg;
    logic               sel_ctrl;
    logic               sel_vec;
    logic               ack_hit;
    logic [N_SRC-1:0]   ack_mask;
    logic [N_SRC-1:0]   w1c_mask;
    logic               unused_wdata;

    // Address decode shared by reads and writes
    assign sel_en   = (sys_addr == ADDR_EN);
    assign sel_flg  = (sys_addr == ADDR_FLG);
    assign sel_ctrl = (sys_addr == ADDR_CTRL);
    assign sel_vec  = (sys_addr == ADDR_VEC);

    assign unused_wdata = ^sys_sw_value;

    assign pending  = flg & inten;
    assign pend_ext = 32'(pending);

    // Lowest pending index wins
    always_comb begin
        winner = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                winner = ID_W'(i);
            end
        end
    end

    // Flag update: W1C and ack clear, but a same-cycle event always sets
    assign ack_hit  = (state == ST_REQ) && irq_ack;
    assign ack_mask = ack_hit ? N_SRC'(32'd1 << irq_id) : '0;
    assign w1c_mask = (sys_wr_en && sel_flg) ? sys_sw_value[N_SRC-1:0] : '0;
    assign flg_nxt  = (flg & ~(w1c_mask | ack_mask)) | src_event;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            inten <= '0;
            flg   <= '0;
            gie   <= 1'b0;
        end else begin
            flg <= flg_nxt;
            if (sys_wr_en && sel_en) begin
                inten <= sys_sw_value[N_SRC-1:0];
            end
            if (sys_wr_en && sel_ctrl) begin
                gie <= sys_sw_value[0];
            end
        end
    end

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; ack takes precedence over withdrawal
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gie && (pending != '0)) begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    state_nxt = ST_SERVICE;
                end else if (!pend_ext[irq_id] || !gie) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; id only latched on entry to REQ so it never preempts
    always_comb begin
        req_nxt = 1'b0;
        id_nxt  = irq_id;
        if (state_nxt == ST_REQ) begin
            req_nxt = 1'b1;
        end
        if ((state == ST_IDLE) && (state_nxt == ST_REQ)) begin
            id_nxt = winner;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            irq_req <= req_nxt;
            irq_id  <= id_nxt;
        end
    end

    // Read mux, zero when no register is addressed
    always_comb begin
        sfr_rd_dout = '0;
        if (sel_en) begin
            sfr_rd_dout = DATA_WIDTH'(inten);
        end else if (sel_flg) begin
            sfr_rd_dout = DATA_WIDTH'(flg);
        end else if (sel_ctrl) begin
            sfr_rd_dout = DATA_WIDTH'(gie);
        end else if (sel_vec) begin
            sfr_rd_dout[DATA_WIDTH-1] = (state == ST_SERVICE);
            sfr_rd_dout[DATA_WIDTH-2] = irq_req;
            sfr_rd_dout[ID_W-1:0]     = irq_id;
        end
    end

endmodule
